mult_seq_sched: RTL and testbench

MULT_SEQ_SCHED -- requirements
Module: mult_seq_sched

---
 rtl/mult_seq_sched.sv | 117 +++++++++++
 tb/tb_mult_seq_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_sched.sv
// Two-requester sequential shift-add multiplier: one product per BW-cycle run, arbitrated from IDLE.
// Optional macro MULT_SEQ_RR_EN selects round-robin arbitration; default is fixed priority to requester 0.
module mult_seq_sched #(
    parameter int AW = 4,
    parameter int BW = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic [AW-1:0]      a0,
    input  logic [AW-1:0]      a1,
    input  logic [BW-1:0]      b0,
    input  logic [BW-1:0]      b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic [AW+BW-1:0]   res
);
    localparam int RW = AW + BW;
    localparam int CW = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [CW-1:0] LAST = CW'(BW - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [RW-1:0] a_sh;
    logic [BW-1:0] b_sh;
    logic [RW-1:0] acc;
    logic [RW-1:0] acc_next;
    logic [CW-1:0] cnt;
    logic          owner;
    logic          pick1;
    logic          any_req;

    assign any_req = req0 | req1;

`ifdef MULT_SEQ_RR_EN
    // rr_ptr=1 means requester 1 wins the next tie.
    logic rr_ptr;
    assign pick1 = req1 & (~req0 | rr_ptr);
`else
    assign pick1 = req1 & ~req0;
`endif

    // a_sh holds a << cnt and b_sh holds b >> cnt, so bit b[cnt] is always b_sh[0].
    always_comb begin
        acc_next = acc;
        if (b_sh[0]) begin
            acc_next = acc + a_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            owner   <= 1'b0;
            res     <= '0;
            done_id <= 1'b0;
            done    <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
`ifdef MULT_SEQ_RR_EN
            rr_ptr  <= 1'b0;
`endif
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        a_sh  <= RW'(pick1 ? a1 : a0);
                        b_sh  <= pick1 ? b1 : b0;
                        acc   <= '0;
                        cnt   <= '0;
                        owner <= pick1;
                        gnt0  <= ~pick1;
                        gnt1  <= pick1;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef MULT_SEQ_RR_EN
                        rr_ptr <= ~pick1;
`endif
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        res     <= acc_next;
                        done_id <= owner;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_sched.sv
// Bench for mult_seq_sched: directed table, multi-cycle corner sequences and a random
// phase checked against a transaction-level model (grant slots, winner, product, due cycle).
module tb_mult_seq_sched;
    localparam int AW = 4;
    localparam int BW = 3;
    localparam int RW = AW + BW;

    logic          clk;
    logic          rst;
    logic          req0, req1;
    logic [AW-1:0] a0, a1;
    logic [BW-1:0] b0, b1;
    logic          gnt0, gnt1, busy, done, done_id;
    logic [RW-1:0] res;

    mult_seq_sched #(.AW(AW), .BW(BW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .busy(busy), .done(done), .done_id(done_id), .res(res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic          id;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [RW-1:0] exp_res;
    } vec_t;
    vec_t vecs[8];

    // scoreboard: {id, product} plus the cycle its done pulse is due
    logic [RW:0] exp_q[$];
    int          due_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_any_gnt(output int n, output logic who, output logic ok);
        n = 0; who = 1'b0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (gnt0 || gnt1) begin
                ok  = 1'b1;
                who = gnt1;
                check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 0);
                check("busy_at_gnt", {31'd0, busy}, 1);
                break;
            end
        end
        if (!ok) check("gnt_timeout", 0, 1);
    endtask

    // call right after the gnt cycle; checks latency, product, owner and single-cycle gnt
    task automatic wait_done(input logic [RW-1:0] er, input logic eid, input string name);
        int   lat;
        logic seen;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (lat == 1) check({name, "_gnt_width"}, {30'd0, gnt1, gnt0}, 0);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, {31'd0, seen}, 1);
        check({name, "_latency"}, lat, BW);
        check({name, "_res"}, {25'd0, res}, {25'd0, er});
        check({name, "_id"}, {31'd0, done_id}, {31'd0, eid});
    endtask

    task automatic run_one(input logic id, input logic [AW-1:0] a, input logic [BW-1:0] b,
                           input logic [RW-1:0] er, input string name);
        int   n;
        logic who, ok;
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; end
        wait_any_gnt(n, who, ok);
        req0 = 1'b0; req1 = 1'b0;
        a0 = 4'($urandom_range(0, 15)); a1 = 4'($urandom_range(0, 15));
        b0 = 3'($urandom_range(0, 7));  b1 = 3'($urandom_range(0, 7));
        if (ok) begin
            check({name, "_winner"}, {31'd0, who}, {31'd0, id});
            wait_done(er, id, name);
            step();
            check({name, "_done_width"}, {31'd0, done}, 0);
            check({name, "_idle_busy"}, {31'd0, busy}, 0);
            check({name, "_res_hold"}, {25'd0, res}, {25'd0, er});
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"}, {27'd0, gnt0, gnt1, busy, done, done_id}, 0);
        check({name, "_res"}, {25'd0, res}, 0);
    endtask

    initial begin
        int   n;
        logic who, ok, any_done;
        logic p0, p1, pend0, pend1, last, exp_g, w, stop;
        int   next_ok, prod;
        logic [RW:0] hd;

        rst = 1'b1; req0 = 0; req1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0;
        step(); step();
        check_all_zero("reset");
        rst = 1'b0;

        vecs[0] = '{1'b0, 4'd5,  3'd3, 7'd15};
        vecs[1] = '{1'b1, 4'd15, 3'd7, 7'd105};
        vecs[2] = '{1'b1, 4'd0,  3'd7, 7'd0};
        vecs[3] = '{1'b0, 4'd0,  3'd0, 7'd0};
        vecs[4] = '{1'b0, 4'd15, 3'd0, 7'd0};
        vecs[5] = '{1'b1, 4'd1,  3'd1, 7'd1};
        vecs[6] = '{1'b0, 4'd9,  3'd5, 7'd45};
        vecs[7] = '{1'b1, 4'd12, 3'd6, 7'd72};
        for (int i = 0; i < 8; i++) begin
            run_one(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_res, $sformatf("vec%0d", i));
        end

        // req1 arrives mid-run of requester 0: waits until IDLE
        req0 = 1'b1; a0 = 5; b0 = 3;
        wait_any_gnt(n, who, ok);
        check("mid_first", {31'd0, who}, 0);
        req0 = 1'b0; req1 = 1'b1; a1 = 6; b1 = 5;
        wait_done(7'd15, 1'b0, "mid_r0");
        wait_any_gnt(n, who, ok);
        check("mid_gap", BW + n, BW + 2);
        check("mid_second", {31'd0, who}, 1);
        req1 = 1'b0;
        wait_done(7'd30, 1'b1, "mid_r1");

        // tie from reset: requester 0 first either way, gnts BW+2 apart
        step(); do_reset();
        req0 = 1'b1; a0 = 2; b0 = 7; req1 = 1'b1; a1 = 4; b1 = 2;
        wait_any_gnt(n, who, ok);
        check("tie_first", {31'd0, who}, 0);
        req0 = 1'b0;
        wait_done(7'd14, 1'b0, "tie_r0");
        wait_any_gnt(n, who, ok);
        check("tie_gap", BW + n, BW + 2);
        check("tie_second", {31'd0, who}, 1);
        req1 = 1'b0;
        wait_done(7'd8, 1'b1, "tie_r1");

        // req0 re-asserted right at its done while req1 waits
        step(); do_reset();
        req0 = 1'b1; a0 = 3; b0 = 3; req1 = 1'b1; a1 = 4; b1 = 2;
        wait_any_gnt(n, who, ok);
        check("re_first", {31'd0, who}, 0);
        req0 = 1'b0;
        wait_done(7'd9, 1'b0, "re_r0");
        req0 = 1'b1; a0 = 7; b0 = 1;
        wait_any_gnt(n, who, ok);
`ifdef MULT_SEQ_RR_EN
        check("re_second", {31'd0, who}, 1);
        req1 = 1'b0;
        wait_done(7'd8, 1'b1, "re_r1");
        wait_any_gnt(n, who, ok);
        req0 = 1'b0;
        wait_done(7'd7, 1'b0, "re_r0b");
`else
        check("re_second", {31'd0, who}, 0);
        req0 = 1'b0;
        wait_done(7'd7, 1'b0, "re_r0b");
        wait_any_gnt(n, who, ok);
        req1 = 1'b0;
        wait_done(7'd8, 1'b1, "re_r1");
`endif

        // reset in the 2nd RUN cycle abandons the product
        step();
        req0 = 1'b1; a0 = 5; b0 = 3;
        wait_any_gnt(n, who, ok);
        req0 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("midrst");
        any_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            any_done = any_done | done;
        end
        check("midrst_no_done", {31'd0, any_done}, 0);
        run_one(1'b0, 4'd5, 3'd3, 7'd15, "after_rst");

        // random phase against the transaction model
        do_reset();
        p0 = 0; p1 = 0; last = 1'b1; next_ok = cyc; stop = 0;
        for (int i = 0; i < 700; i++) begin
            stop = (i >= 500);
            if (!p0) begin
                a0 = 4'($urandom_range(0, 15)); b0 = 3'($urandom_range(0, 7));
                if (!stop && $urandom_range(0, 3) == 0) p0 = 1'b1;
            end
            if (!p1) begin
                a1 = 4'($urandom_range(0, 15)); b1 = 3'($urandom_range(0, 7));
                if (!stop && $urandom_range(0, 3) == 0) p1 = 1'b1;
            end
            req0 = p0; req1 = p1;
            pend0 = p0; pend1 = p1;
            step();
            exp_g = (pend0 || pend1) && (cyc >= next_ok);
            if ((gnt0 | gnt1) !== exp_g) check("rnd_gnt_slot", {31'd0, gnt0 | gnt1}, {31'd0, exp_g});
            if (gnt0 && gnt1) check("rnd_gnt_excl", 1, 0);
            if (exp_g) begin
`ifdef MULT_SEQ_RR_EN
                w = (pend0 && pend1) ? ~last : pend1;
`else
                w = ~pend0;
`endif
                check("rnd_arb", {31'd0, gnt1}, {31'd0, w});
                prod = w ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
                exp_q.push_back({w, RW'(prod)});
                due_q.push_back(cyc + BW);
                if (w) p1 = 1'b0; else p0 = 1'b0;
                next_ok = cyc + BW + 2;
                last = w;
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                hd = exp_q.pop_front();
                void'(due_q.pop_front());
                check("rnd_done", {31'd0, done}, 1);
                check("rnd_res", {25'd0, res}, {25'd0, hd[RW-1:0]});
                check("rnd_id", {31'd0, done_id}, {31'd0, hd[RW]});
            end else if (done) begin
                check("rnd_spurious_done", {31'd0, done}, 0);
            end
            if (stop && !p0 && !p1 && exp_q.size() == 0) break;
        end
        check("rnd_drain", exp_q.size() + int'(p0) + int'(p1), 0);
        req0 = 0; req1 = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
